// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment driver with decimal (double-dabble) or hex display.
// Decimal load commits after DATA_W+1 busy cycles, hex after 1; loads are dropped while busy. Optional: SEG7_LZ_BLANK_EN.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DATA_W       = 14,
    parameter int REFRESH_BITS = 18
) (
    input  logic                  clock_100Mhz,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     number,
    input  logic                  load,
    input  logic                  hex_mode,
    input  logic [NUM_DIGITS-1:0] dp_in,
    output logic                  busy,
    output logic [NUM_DIGITS-1:0] Anode_Activate,
    output logic [6:0]            LED_out,
    output logic                  DP_out
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    localparam logic [6:0] GLYPH_DASH  = 7'b1111110;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    logic [1:0]              state;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_W-1:0]       bin;
    logic [BCD_W-1:0]        bcd;
    logic [BCD_W-1:0]        bcd_adj;
    logic                    ovf;
    logic [NUM_DIGITS-1:0]   dp_lat;
    logic [BCD_W-1:0]        disp_bcd;
    logic                    disp_ovf;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [REFRESH_BITS-1:0] refresh_cnt;
    logic [IDX_W-1:0]        scan_idx;
    logic [3:0]              cur_dig;
    logic                    cur_dp;
    logic                    cur_lz;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    hex_ovf;
`ifdef SEG7_LZ_BLANK_EN
    logic                    hex_lat;
    logic                    disp_hex;
    logic                    upper_zero;
`endif

    assign busy = (state != S_IDLE);

    if (DATA_W > BCD_W) begin : g_hex_ovf
        assign hex_ovf = |number[DATA_W-1:BCD_W];
    end else begin : g_no_hex_ovf
        assign hex_ovf = 1'b0;
    end

    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bin      <= '0;
            bcd      <= '0;
            ovf      <= 1'b0;
            dp_lat   <= '0;
            disp_bcd <= '0;
            disp_ovf <= 1'b0;
            disp_dp  <= '0;
`ifdef SEG7_LZ_BLANK_EN
            hex_lat  <= 1'b0;
            disp_hex <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (load) begin
                        bin    <= number;
                        dp_lat <= dp_in;
                        cnt    <= '0;
`ifdef SEG7_LZ_BLANK_EN
                        hex_lat <= hex_mode;
`endif
                        if (hex_mode) begin
                            bcd   <= BCD_W'(number);
                            ovf   <= hex_ovf;
                            state <= S_COMMIT;
                        end else begin
                            bcd   <= '0;
                            ovf   <= 1'b0;
                            state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    // A 1 leaving the BCD MSB means the value needs more digits than we have.
                    bcd <= {bcd_adj[BCD_W-2:0], bin[DATA_W-1]};
                    bin <= {bin[DATA_W-2:0], 1'b0};
                    ovf <= ovf | bcd_adj[BCD_W-1];
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(DATA_W - 1))
                        state <= S_COMMIT;
                end
                S_COMMIT: begin
                    disp_bcd <= bcd;
                    disp_ovf <= ovf;
                    disp_dp  <= dp_lat;
`ifdef SEG7_LZ_BLANK_EN
                    disp_hex <= hex_lat;
`endif
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    // Blank a decimal digit when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        lz_blank   = '0;
        upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            upper_zero  = upper_zero & (disp_bcd[4*k +: 4] == 4'd0);
            lz_blank[k] = upper_zero & ~disp_hex;
        end
    end
`else
    assign lz_blank = '0;
`endif

    always_comb begin
        cur_dig = '0;
        cur_dp  = 1'b0;
        cur_lz  = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (scan_idx == IDX_W'(k)) begin
                cur_dig = disp_bcd[4*k +: 4];
                cur_dp  = disp_dp[k];
                cur_lz  = lz_blank[k];
            end
        end
    end

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0:    glyph = 7'b0000001;
            4'h1:    glyph = 7'b1001111;
            4'h2:    glyph = 7'b0010010;
            4'h3:    glyph = 7'b0000110;
            4'h4:    glyph = 7'b1001100;
            4'h5:    glyph = 7'b0100100;
            4'h6:    glyph = 7'b0100000;
            4'h7:    glyph = 7'b0001111;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0000100;
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b1100000;
            4'hC:    glyph = 7'b0110001;
            4'hD:    glyph = 7'b1000010;
            4'hE:    glyph = 7'b0110000;
            default: glyph = 7'b0111000;
        endcase
    endfunction

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            refresh_cnt    <= '0;
            scan_idx       <= '0;
            Anode_Activate <= '1;
            LED_out        <= GLYPH_BLANK;
            DP_out         <= 1'b1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
            if (&refresh_cnt)
                scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
            Anode_Activate <= ~(NUM_DIGITS'(1) << scan_idx);
            LED_out        <= disp_ovf ? GLYPH_DASH : (cur_lz ? GLYPH_BLANK : glyph(cur_dig));
            DP_out         <= ~cur_dp;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl (4 digits, 14-bit operand, 4-clock digit period).
`timescale 1ns/1ps
module tb_seg7_scan_ctrl;
    localparam int N  = 4;
    localparam int DW = 14;
    localparam int RB = 2;

`ifdef SEG7_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010, G3 = 7'b0000110;
    localparam logic [6:0] G4 = 7'b1001100, G5 = 7'b0100100, G7 = 7'b0001111;
    localparam logic [6:0] GA = 7'b0001000, GF = 7'b0111000;
    localparam logic [6:0] DASH = 7'b1111110, BLANK = 7'b1111111;
    localparam logic [6:0] ZU = LZ ? BLANK : G0;

    logic          clk = 1'b0;
    logic          reset, load, hex_mode;
    logic [DW-1:0] number;
    logic [N-1:0]  dp_in;
    logic          busy;
    logic [N-1:0]  anode;
    logic [6:0]    led;
    logic          dp_out;

    int errors = 0;
    int checks = 0;
    int cyc;

    logic [6:0] seen_led [N];
    logic       seen_dp  [N];
    logic [N-1:0] seen;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.NUM_DIGITS(N), .DATA_W(DW), .REFRESH_BITS(RB)) dut (
        .clock_100Mhz   (clk),
        .reset          (reset),
        .number         (number),
        .load           (load),
        .hex_mode       (hex_mode),
        .dp_in          (dp_in),
        .busy           (busy),
        .Anode_Activate (anode),
        .LED_out        (led),
        .DP_out         (dp_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [DW-1:0] n, input logic h, input logic [N-1:0] d);
        number   = n;
        hex_mode = h;
        dp_in    = d;
        load     = 1'b1;
        step();
        load     = 1'b0;
    endtask

    task automatic wait_idle(output int c);
        c = 0;
        while (busy && c < 100) begin
            c++;
            step();
        end
    endtask

    // One full scan plus margin; records what each anode position showed.
    task automatic capture();
        seen = '0;
        repeat (20) begin
            step();
            for (int k = 0; k < N; k++) begin
                if (anode == ~(N'(1) << k)) begin
                    seen[k]     = 1'b1;
                    seen_led[k] = led;
                    seen_dp[k]  = dp_out;
                end
            end
        end
    endtask

    task automatic expect_digits(input string tag, input logic [6:0] g3, input logic [6:0] g2,
                                 input logic [6:0] g1, input logic [6:0] g0);
        capture();
        check({tag, "_all_scanned"}, seen, {N{1'b1}});
        check({tag, "_d3"}, seen_led[3], g3);
        check({tag, "_d2"}, seen_led[2], g2);
        check({tag, "_d1"}, seen_led[1], g1);
        check({tag, "_d0"}, seen_led[0], g0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; load = 1'b0; number = '0; hex_mode = 1'b0; dp_in = '0;
        repeat (3) step();
        check("rst_anode", anode, 4'b1111);
        check("rst_led", led, BLANK);
        check("rst_dp", dp_out, 1'b1);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;

        step();
        check("scan0_anode", anode, 4'b1110);
        check("scan0_led", led, G0);
        repeat (4) step();
        check("scan1_anode", anode, 4'b1101);
        check("scan1_led", led, ZU);
        repeat (4) step();
        check("scan2_anode", anode, 4'b1011);
        check("scan2_led", led, ZU);
        repeat (4) step();
        check("scan3_anode", anode, 4'b0111);
        check("scan3_led", led, ZU);

        do_load(14'd1234, 1'b0, 4'b0000);
        wait_idle(cyc);
        check("dec1234_busy_cycles", cyc, 15);
        expect_digits("dec1234", G1, G2, G3, G4);

        do_load(14'd10000, 1'b0, 4'b0000);
        wait_idle(cyc);
        check("ovf_busy_cycles", cyc, 15);
        expect_digits("ovf", DASH, DASH, DASH, DASH);

        do_load(14'h3A5F, 1'b1, 4'b0100);
        wait_idle(cyc);
        check("hex_busy_cycles", cyc, 1);
        expect_digits("hex", G3, GA, G5, GF);
        check("hex_dp3", seen_dp[3], 1'b1);
        check("hex_dp2", seen_dp[2], 1'b0);
        check("hex_dp1", seen_dp[1], 1'b1);
        check("hex_dp0", seen_dp[0], 1'b1);

        // A second load arriving mid-conversion must be dropped.
        do_load(14'd1234, 1'b0, 4'b0000);
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            load   = (cyc == 4);
            number = 14'd5678;
            step();
        end
        load = 1'b0;
        check("ignored_busy_cycles", cyc, 15);
        expect_digits("ignored", G1, G2, G3, G4);
        check("ignored_dp0", seen_dp[0], 1'b1);

        do_load(14'd7, 1'b0, 4'b0000);
        wait_idle(cyc);
        expect_digits("dec7", ZU, ZU, ZU, G7);

        do_load(14'd9999, 1'b0, 4'b1111);
        repeat (4) step();
        check("abort_busy_before", busy, 1'b1);
        reset = 1'b1;
        step();
        check("abort_busy", busy, 1'b0);
        check("abort_anode", anode, 4'b1111);
        check("abort_led", led, BLANK);
        check("abort_dp", dp_out, 1'b1);
        reset = 1'b0;
        expect_digits("abort", ZU, ZU, ZU, G0);
        check("abort_dp3", seen_dp[3], 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Parametrised multiplexed seven-segment display controller for the lab FPGA boards. It drives NUM_DIGITS common-anode digits from a binary operand and shows the value in decimal or hexadecimal. Decimal conversion uses a sequential shift-add-3 (double-dabble) engine, so no combinational divide or modulo is needed. It sits between user logic (counters, ALU results) and the board's anode and cathode pins, and supersedes the fixed 4-digit, fixed-decimal display driver.

## Interface
- NUM_DIGITS, 4: digits driven (1..8).
- DATA_W, 14: operand width (≤ 4*NUM_DIGITS).
- REFRESH_BITS, 18: digit period is 2^REFRESH_BITS clocks (2.62 ms at 100 MHz).
- clock_100Mhz  in  1  system clock, the only clock.
- reset  in  1  synchronous, active-high reset.
- number  in  DATA_W  unsigned operand, sampled on accepted load.
- load  in  1  request to capture number, hex_mode and dp_in; accepted only when busy=0.
- hex_mode  in  1  1 = hex digits, 0 = decimal digits.
- dp_in  in  NUM_DIGITS  per-digit decimal point request, active-high (bit k = digit k).
- busy  out  1  conversion in progress.
- Anode_Activate  out  NUM_DIGITS  anode enables, active-low (bit k = digit k, digit 0 = least significant, rightmost).
- LED_out  out  7  cathodes {a,b,c,d,e,f,g}, active-low.
- DP_out  out  1  decimal-point cathode, active-low.

## Operation
- Conversion FSM states:
  - IDLE: if load=1, latch number, hex_mode and dp_in. Go to SHIFT when hex_mode=0, or to COMMIT when hex_mode=1.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, bin} left 1. After DATA_W shifts, go to COMMIT.
  - COMMIT: copy the result into the display registers, then return to IDLE.
- busy = (state != IDLE).
- load while busy=1 is ignored; it is not queued.
- BCD register is 4*NUM_DIGITS bits wide. A sticky overflow flag is set if any shift pushes a 1 out of the BCD MSB.
- Hex overflow: any set bit of number at or above bit 4*NUM_DIGITS.
- When overflow is set, the COMMIT stores all digits as dash.
- Display registers hold the old value for the whole conversion. They update atomically only in COMMIT.
- Scan:
  - The REFRESH_BITS counter free-runs.
  - Digit index k increments on counter wrap and wraps from NUM_DIGITS-1 to 0.
  - Anode bit k is driven low and all other anode bits high.
  - LED_out shows digit k; DP_out = ~dp[k].
- Glyphs (active-low):
  - Decimal: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - Hex: A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - Dash = 1111110. Blank = 1111111.

## Timing
- Reset values: Anode_Activate all ones, LED_out 1111111, DP_out 1, busy 0, state IDLE.
- Reset also clears: display digits to 0, dp to 0, scan index and refresh counter to 0, overflow flag.
- Anode_Activate, LED_out and DP_out are registered. They reflect the scan index one clock after it changes.
- The first edge after reset release drives digit 0.
- Decimal load sampled at edge T0:
  - busy is high from T0+1 through T0+DATA_W+1.
  - New digits are visible in the display registers from T0+DATA_W+2, shown when their digit is next scanned.
- Hex load: busy is high for exactly 1 cycle, and the display registers update at T0+2.
- Reset asserted mid-conversion aborts the conversion on that edge; the outputs take their reset values.
- The scan never stalls during conversion.

## Configuration
- SEG7_LZ_BLANK_EN defined:
  - In decimal mode, digits above the most significant nonzero digit show blank (1111111).
  - Digit 0 is never blanked.
  - Blanked digits still honour dp_in.
  - Hex mode and dash overflow display are unaffected.
- SEG7_LZ_BLANK_EN undefined: all digits are always shown, including leading zeros.

## Test plan
(All scenarios use NUM_DIGITS=4, DATA_W=14, REFRESH_BITS=2.)
- Reset held 3 cycles -> Anode_Activate=1111, LED_out=1111111, DP_out=1 and busy=0. After release, scan shows 0000001 on each digit, with Anode cycling 1110, 1101, 1011, 0111.
- Decimal load of 1234 -> busy=1 for 15 cycles, then Anode 0111/1011/1101/1110 show 1001111/0010010/0000110/1001100.
- Decimal load of 10000 -> overflow; every digit shows 1111110.
- Hex load of 0x3A5F with dp_in=0100 -> digits show 0000110/0001000/0100100/0111000, and DP_out=0 only while Anode=1011.
- Load of 5678 asserted 4 cycles into the 1234 conversion -> ignored; the display ends at 1234.
- Decimal load of 7:
  - With SEG7_LZ_BLANK_EN, Anode 0111/1011/1101 show 1111111 and Anode 1110 shows 0001111.
  - Without the macro, Anode 0111/1011/1101 show 0000001.
- Additional scenario: reset asserted 5 cycles into a conversion -> busy=0 on the next edge and the display returns to 0000.
